imem_loader: RTL and testbench

//   Write-side companion of the instruction memory: receives a program as a byte

---
 rtl/imem_loader_if.sv | 42 ++++
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ----------------------------------------------------------------------------
// imem_loader_if
//   Bundles the byte-stream handshake, the imem write port and the load status
//   lines of the instruction-memory loader.
//   master : byte source / system controller (drives start, in_valid, in_data)
//   slave  : the loader (drives in_ready, mem_*, cpu_hold, done, error)
//   Signals:
//     start      1       pulse: begin a new load
//     in_valid   1       stream byte valid
//     in_data    8       stream byte
//     in_ready   1       loader accepts byte
//     mem_we     1       imem write strobe
//     mem_addr   ADDR_W  imem word address
//     mem_wdata  32      imem write data
//     cpu_hold   1       core must stay stalled
//     done       1       load completed (level)
//     error      1       header word count too large (level)
// ----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Receives a program as a little-endian byte stream and writes it into the
//   instruction memory as 32-bit words at sequential addresses from 0.
//   Stream: LEN0, LEN1 (16-bit word count N), then N words, LSB byte first.
//   The core is held (cpu_hold) while a load runs and after a failed load.
//   Ports:
//     clk    in  clock, posedge
//     rst_n  in  synchronous active-low reset
//     bus    slave side of imem_loader_if (stream in, imem write out, status)
//   All outputs are registered.
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nx;

    // registered outputs
    logic              in_ready_q, in_ready_nx;
    logic              mem_we_q, mem_we_nx;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nx;
    logic [31:0]       mem_wdata_q, mem_wdata_nx;
    logic              cpu_hold_q, cpu_hold_nx;
    logic              done_q, done_nx;
    logic              error_q, error_nx;

    // datapath state
    logic [7:0]        len_lo, len_lo_nx;
    logic [23:0]       wbuf, wbuf_nx;      // lanes 0..2 of the word in flight
    logic [1:0]        bidx, bidx_nx;
    logic [CNT_W-1:0]  rem, rem_nx;        // words still to be received
    logic [ADDR_W-1:0] waddr, waddr_nx;    // address of the next word

    logic              xfer;
    logic [15:0]       nwords;

    assign xfer   = bus.in_valid & in_ready_q;
    assign nwords = {bus.in_data, len_lo};

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            len_lo      <= '0;
            wbuf        <= '0;
            bidx        <= '0;
            rem         <= '0;
            waddr       <= '0;
        end else begin
            state       <= state_nx;
            in_ready_q  <= in_ready_nx;
            mem_we_q    <= mem_we_nx;
            mem_addr_q  <= mem_addr_nx;
            mem_wdata_q <= mem_wdata_nx;
            cpu_hold_q  <= cpu_hold_nx;
            done_q      <= done_nx;
            error_q     <= error_nx;
            len_lo      <= len_lo_nx;
            wbuf        <= wbuf_nx;
            bidx        <= bidx_nx;
            rem         <= rem_nx;
            waddr       <= waddr_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        in_ready_nx  = in_ready_q;
        mem_we_nx    = 1'b0;               // write strobe is a one-cycle pulse
        mem_addr_nx  = mem_addr_q;
        mem_wdata_nx = mem_wdata_q;
        cpu_hold_nx  = cpu_hold_q;
        done_nx      = done_q;
        error_nx     = error_q;
        len_lo_nx    = len_lo;
        wbuf_nx      = wbuf;
        bidx_nx      = bidx;
        rem_nx       = rem;
        waddr_nx     = waddr;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_nx    = S_LEN0;
                    in_ready_nx = 1'b1;
                    cpu_hold_nx = 1'b1;
                    done_nx     = 1'b0;
                    error_nx    = 1'b0;
                    mem_addr_nx = '0;
                    waddr_nx    = '0;
                    bidx_nx     = '0;
                end
            end

            S_LEN0: begin
                if (xfer) begin
                    len_lo_nx = bus.in_data;
                    state_nx  = S_LEN1;
                end
            end

            S_LEN1: begin
                if (xfer) begin
                    if (nwords == 16'd0) begin
                        state_nx    = S_DONE;
                        in_ready_nx = 1'b0;
                        cpu_hold_nx = 1'b0;
                        done_nx     = 1'b1;
                    end else if ({16'd0, nwords} > 32'(DEPTH)) begin
                        state_nx    = S_ERR;
                        in_ready_nx = 1'b0;
                        error_nx    = 1'b1;
                    end else begin
                        state_nx = S_DATA;
                        bidx_nx  = '0;
                        rem_nx   = CNT_W'(nwords);
                    end
                end
            end

            S_DATA: begin
                // in_ready drops only after the last byte has been taken; the
                // following cycle is the final write, after which the load ends.
                if (!in_ready_q) begin
                    state_nx    = S_DONE;
                    cpu_hold_nx = 1'b0;
                    done_nx     = 1'b1;
                end else if (xfer) begin
                    bidx_nx = bidx + 2'd1;
                    case (bidx)
                        2'd0: wbuf_nx[7:0]   = bus.in_data;
                        2'd1: wbuf_nx[15:8]  = bus.in_data;
                        2'd2: wbuf_nx[23:16] = bus.in_data;
                        default: begin
                            mem_we_nx    = 1'b1;
                            mem_wdata_nx = {bus.in_data, wbuf};
                            mem_addr_nx  = waddr;
                            waddr_nx     = waddr + ADDR_W'(1);
                            rem_nx       = rem - CNT_W'(1);
                            if (rem == CNT_W'(1))
                                in_ready_nx = 1'b0;
                        end
                    endcase
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader: a table of load scenarios with expected
//   writes and final status, plus hand sequences for reset mid-load and a
//   full-depth load.
// ----------------------------------------------------------------------------
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int LOGN   = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        int          nb;
        logic [95:0] bytes;     // first stream byte in the most significant used byte
        bit          gap;
        bit          start_mid;
        int          exp_n;
        logic [9:0]  a0, a1;
        logic [31:0] d0, d1;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs [5];

    int n_vec = 0;
    int n_bad = 0;

    // write monitor, sampled on the falling edge
    int          wr_n = 0;
    int          pulse_bad = 0;
    bit          prev_we = 1'b0;
    logic [9:0]  wa [LOGN];
    logic [31:0] wd [LOGN];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (wr_n < LOGN) begin
                wa[wr_n] = bus.mem_addr;
                wd[wr_n] = bus.mem_wdata;
            end
            wr_n++;
            if (prev_we) pulse_bad++;
        end
        prev_we = (bus.mem_we === 1'b1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done === 1'b1 || bus.error === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
        chk({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
        chk({tag, "_error"},     32'(bus.error),     32'd0);
    endtask

    task automatic do_reset(input string tag);
        int base;
        base = wr_n;
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (2) tick();
        check_idle_outputs(tag);
        chk({tag, "_no_writes"}, 32'(wr_n - base), 32'd0);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        check_idle_outputs({tag, "_rel"});
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   base, pb;
        bit   ok;
        v    = vecs[k];
        base = wr_n;
        pb   = pulse_bad;
        pulse_start();
        chk({v.name, "_hold_on_start"},  32'(bus.cpu_hold), 32'd1);
        chk({v.name, "_ready_on_start"}, 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < v.nb; i++) begin
            if (v.gap) repeat ($urandom_range(0, 5)) tick();
            if (v.start_mid && i == 5) pulse_start();
            send_byte(v.bytes[(v.nb - 1 - i) * 8 +: 8]);
        end
        wait_end(ok);
        chk({v.name, "_end_seen"}, 32'(ok), 32'd1);
        // keep offering bytes after the end: nothing may be accepted or written
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        repeat (6) tick();
        bus.in_valid = 1'b0;
        tick();
        chk({v.name, "_nwrites"}, 32'(wr_n - base), 32'(v.exp_n));
        if (v.exp_n > 0 && wr_n - base > 0) begin
            chk({v.name, "_addr0"}, 32'(wa[base]), 32'(v.a0));
            chk({v.name, "_data0"}, wd[base], v.d0);
        end
        if (v.exp_n > 1 && wr_n - base > 1) begin
            chk({v.name, "_addr1"}, 32'(wa[base + 1]), 32'(v.a1));
            chk({v.name, "_data1"}, wd[base + 1], v.d1);
        end
        chk({v.name, "_done"},     32'(bus.done),     32'(v.exp_done));
        chk({v.name, "_error"},    32'(bus.error),    32'(v.exp_err));
        chk({v.name, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(v.exp_err));
        chk({v.name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({v.name, "_we_pulse"}, 32'(pulse_bad - pb), 32'd0);
    endtask

    function automatic logic [31:0] fw(input int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
    endfunction

    initial begin
        int   base, mism;
        bit   ok;
        logic [31:0] w;

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        vecs[0] = '{"two_word", 10, 96'h02001305100093051500, 1'b0, 1'b0,
                    2, 10'd0, 10'd1, 32'h00100513, 32'h00150593, 1'b1, 1'b0};
        vecs[1] = '{"zero_cnt", 2, 96'h0000, 1'b0, 1'b0,
                    0, 10'd0, 10'd0, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[2] = '{"oversize", 2, 96'h0104, 1'b0, 1'b0,
                    0, 10'd0, 10'd0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[3] = '{"gapped", 10, 96'h02001305100093051500, 1'b1, 1'b1,
                    2, 10'd0, 10'd1, 32'h00100513, 32'h00150593, 1'b1, 1'b0};
        vecs[4] = '{"one_word", 6, 96'h0100EFBEADDE, 1'b0, 1'b0,
                    1, 10'd0, 10'd0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};

        tick();
        do_reset("reset");

        for (int k = 0; k < 5; k++) run_vec(k);

        // reset in the middle of the first data word, then a clean reload
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hEE);
        send_byte(8'hDD);
        chk("midrst_hold_before", 32'(bus.cpu_hold), 32'd1);
        do_reset("midrst");
        run_vec(0);

        // full-depth load: last write lands at DEPTH-1
        base = wr_n;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        for (int i = 0; i < DEPTH; i++) begin
            w = fw(i);
            for (int j = 0; j < 4; j++) send_byte(w[j * 8 +: 8]);
        end
        wait_end(ok);
        chk("full_end_seen", 32'(ok), 32'd1);
        tick();
        chk("full_nwrites", 32'(wr_n - base), 32'(DEPTH));
        mism = 0;
        for (int i = 0; i < DEPTH && base + i < LOGN && i < wr_n - base; i++) begin
            if (wa[base + i] !== 10'(i) || wd[base + i] !== fw(i)) mism++;
        end
        chk("full_mismatch_cnt", 32'(mism), 32'd0);
        if (wr_n - base >= DEPTH)
            chk("full_last_addr", 32'(wa[base + DEPTH - 1]), 32'(DEPTH - 1));
        chk("full_done",     32'(bus.done),     32'd1);
        chk("full_error",    32'(bus.error),    32'd0);
        chk("full_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        chk("full_we_pulse", 32'(pulse_bad),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
